rx_frame_buf: RTL and testbench
===============================

RX_FRAME_BUF -- requirements
Module: rx_frame_buf

Interface
REQ-001 The block SHALL have parameter LANE_W, default 4, giving the MOSI lane width in bits per beat.
REQ-002 The block SHALL have parameter FIELDS, default 5, giving the number of data beats per frame (minimum 2).
REQ-003 The block SHALL have parameter DEPTH, default 2, giving the number of complete-frame FIFO entries (power of 2, minimum 2).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-006 Port: rst  input  1  asynchronous, active-high reset.
REQ-007 Port: spi_clk  input  1  asynchronous SPI clock; data is sampled on its rising edge.
REQ-008 Port: spi_w  input  1  asynchronous write enable; high = frame in progress.
REQ-009 Port: mosi  input  LANE_W  asynchronous beat data.
REQ-010 Port: frame_ready  input  1  downstream accepts the head frame.
REQ-011 Port: frame_valid  output  1  the FIFO is non-empty.
REQ-012 Port: frame_data  output  FIELDS*LANE_W  head frame; beat 0 occupies the MSBs, beat FIELDS-1 the LSBs.
REQ-013 Port: level  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-014 Port: drop  output  1  one-cycle pulse when a completed frame is discarded because the FIFO is full.
REQ-015 Port: drop_cnt  output  8  count of dropped frames, saturating at 255.
REQ-016 Port: parity_err  output  1  one-cycle pulse on a frame parity mismatch (see Configuration).

Function
REQ-017 spi_clk, spi_w and mosi SHALL each pass through a 2-flop synchronizer; a third spi_clk flop SHALL provide edge detection (edge = s2 & ~s3).
REQ-018 A beat SHALL be captured from synchronized mosi only in a cycle with an edge and synchronized spi_w high.
REQ-019 The beat counter SHALL run 0..NB-1, where NB = FIELDS (or FIELDS+1 with parity), and SHALL wrap to 0 after beat NB-1.
REQ-020 Synchronized spi_w low SHALL clear the beat counter and discard any partial frame; FIFO contents are unaffected.
REQ-021 Capturing beat NB-1 SHALL attempt a push of the assembled frame in the same cycle; frame_valid SHALL rise on the next clk edge when the FIFO was empty.
REQ-022 A pop SHALL occur when frame_valid && frame_ready; frame_data SHALL advance to the next entry on the following cycle.
REQ-023 Push while full without a simultaneous pop: the frame SHALL be dropped, drop SHALL pulse, drop_cnt SHALL increment (saturating), and the FIFO SHALL be unchanged.
REQ-024 Push while full with a simultaneous pop: both SHALL occur, and level SHALL stay at DEPTH.
REQ-025 Push and pop in the same cycle with 0 < level < DEPTH: level SHALL be unchanged and ordering SHALL be preserved.
REQ-026 frame_data SHALL be stable while frame_valid && !frame_ready.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH; level SHALL be derived from the pointers and SHALL never exceed DEPTH.

Reset
REQ-028 While rst is high, all synchronizers, the beat counter, the assembly register, the pointers, level=0, frame_valid=0, frame_data=0, drop=0, drop_cnt=0 and parity_err=0 SHALL be held.
REQ-029 Reset asserted mid-frame or with a non-empty FIFO SHALL discard everything; the first frame after release SHALL start at beat 0 once spi_w is high.

Configuration
REQ-030 Macro RX_PARITY_EN defined: NB = FIELDS+1, and the final beat SHALL equal the bitwise XOR of all FIELDS data beats.
REQ-031 With RX_PARITY_EN, on mismatch the frame SHALL NOT be pushed and parity_err SHALL pulse for one cycle; drop SHALL NOT pulse.
REQ-032 Without RX_PARITY_EN: NB = FIELDS, no parity logic is built, and parity_err SHALL be tied to 0.

Verification
REQ-033 Defaults; send beats 1,2,3,4,5 -> frame_data=20'h12345, frame_valid=1, level=1; frame_ready=1 for one cycle -> frame_valid=0.
REQ-034 Defaults; send 3 frames (A..., B..., C...) with frame_ready=0 -> level=2, the third frame is dropped with one drop pulse, drop_cnt=1; pops return A then B.
REQ-035 spi_w dropped after 3 beats, then full frame 6,7,8,9,A -> only 20'h6789A is pushed, level=1.
REQ-036 FIFO full with frame_ready=1 held in the cycle the next final beat is captured -> no drop; level stays 2; output order is preserved.
REQ-037 With RX_PARITY_EN, beats 1,2,3,4,5 then parity 1 (1^2^3^4^5=1) -> pushed; the same beats with parity 0 -> parity_err pulse, level unchanged.
REQ-038 rst asserted after beat 2 with one frame stored -> all outputs reset; a subsequent frame F,E,D,C,B -> frame_data=20'hFEDCB.

Source files
------------

// File: rtl/rx_frame_buf.sv
// rx_frame_buf: samples an asynchronous SPI-style beat stream, assembles
// fixed-length frames and queues complete frames in a small FIFO.
// Optional feature macro: RX_PARITY_EN (adds a trailing XOR parity beat).
module rx_frame_buf #(
    parameter int unsigned LANE_W = 4,
    parameter int unsigned FIELDS = 5,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         spi_clk,
    input  logic                         spi_w,
    input  logic [LANE_W-1:0]            mosi,
    input  logic                         frame_ready,
    output logic                         frame_valid,
    output logic [FIELDS*LANE_W-1:0]     frame_data,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         drop,
    output logic [7:0]                   drop_cnt,
    output logic                         parity_err
);

    localparam int unsigned FW = FIELDS * LANE_W;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
`ifdef RX_PARITY_EN
    localparam int unsigned NB = FIELDS + 1;
`else
    localparam int unsigned NB = FIELDS;
`endif
    localparam int unsigned CW    = $clog2(NB);
    // Holds every beat of a frame except the one captured last.
    localparam int unsigned ASM_W = (NB - 1) * LANE_W;

    logic [2:0]        sclk_sync;
    logic [1:0]        w_sync;
    logic [LANE_W-1:0] m1, m2;
    logic [CW-1:0]     beat_cnt;
    logic [ASM_W-1:0]  asm_reg;
    logic [LW-1:0]     wr_ptr, rd_ptr;
    logic [FW-1:0]     mem [DEPTH];

    logic              rise_c, capture_c, last_c, par_ok_c;
    logic              push_c, pop_c, full_c, push_ok_c, drop_c;
    logic [FW-1:0]     frame_c, head_c;
    logic [LW-1:0]     wr_nxt_c, rd_nxt_c;

    // Synchronize the asynchronous SPI inputs; third spi_clk flop for edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            w_sync    <= '0;
            m1        <= '0;
            m2        <= '0;
        end else begin
            sclk_sync <= {sclk_sync[1:0], spi_clk};
            w_sync    <= {w_sync[0], spi_w};
            m1        <= mosi;
            m2        <= m1;
        end
    end

    assign rise_c    = sclk_sync[1] & ~sclk_sync[2];
    assign capture_c = rise_c & w_sync[1];
    assign last_c    = capture_c && (beat_cnt == CW'(NB - 1));

`ifdef RX_PARITY_EN
    logic [LANE_W-1:0] par_c;

    // XOR of all data beats held in the assembly register.
    always_comb begin
        par_c = '0;
        for (int i = 0; i < int'(FIELDS); i++) begin
            par_c = par_c ^ asm_reg[i*LANE_W +: LANE_W];
        end
    end

    assign par_ok_c = (par_c == m2);
    assign frame_c  = asm_reg;

    // One-cycle pulse when the trailing parity beat disagrees.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) parity_err <= 1'b0;
        else     parity_err <= last_c && !par_ok_c;
    end
`else
    assign par_ok_c   = 1'b1;
    assign frame_c    = {asm_reg, m2};
    assign parity_err = 1'b0;
`endif

    // Beat counter and shift-in assembly; spi_w low abandons a partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
            asm_reg  <= '0;
        end else if (!w_sync[1]) begin
            beat_cnt <= '0;
        end else if (capture_c) begin
            beat_cnt <= last_c ? '0 : beat_cnt + CW'(1);
            asm_reg  <= ASM_W'({asm_reg, m2});
        end
    end

    // FIFO push/pop decisions and the next-head selection.
    always_comb begin
        push_c    = last_c && par_ok_c;
        pop_c     = frame_valid && frame_ready;
        full_c    = (level == LW'(DEPTH));
        push_ok_c = push_c && (!full_c || pop_c);
        drop_c    = push_c && full_c && !pop_c;
        wr_nxt_c  = wr_ptr + LW'(push_ok_c);
        rd_nxt_c  = rd_ptr + LW'(pop_c);
        // A frame written into the slot that becomes the head bypasses storage.
        if (push_ok_c && (wr_ptr[AW-1:0] == rd_nxt_c[AW-1:0])) head_c = frame_c;
        else                                                   head_c = mem[rd_nxt_c[AW-1:0]];
    end

    // Frame storage; contents need no reset because pointers gate their use.
    always_ff @(posedge clk) begin
        if (push_ok_c) mem[wr_ptr[AW-1:0]] <= frame_c;
    end

    // Pointers, registered head/occupancy and drop reporting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            frame_valid <= 1'b0;
            frame_data  <= '0;
            drop        <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            wr_ptr      <= wr_nxt_c;
            rd_ptr      <= rd_nxt_c;
            level       <= wr_nxt_c - rd_nxt_c;
            frame_valid <= (wr_nxt_c != rd_nxt_c);
            frame_data  <= head_c;
            drop        <= drop_c;
            if (drop_c && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_rx_frame_buf.sv
// Bench for rx_frame_buf: queue-based reference model plus a pop monitor.
module tb_rx_frame_buf;

    localparam int unsigned LANE_W = 4;
    localparam int unsigned FIELDS = 5;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned FW     = FIELDS * LANE_W;
    localparam int unsigned LVW    = $clog2(DEPTH) + 1;
`ifdef RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic              clk, rst, spi_clk, spi_w, frame_ready;
    logic [LANE_W-1:0] mosi;
    logic              frame_valid, drop, parity_err;
    logic [FW-1:0]     frame_data;
    logic [LVW-1:0]    level;
    logic [7:0]        drop_cnt;

    rx_frame_buf #(.LANE_W(LANE_W), .FIELDS(FIELDS), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_w(spi_w), .mosi(mosi),
        .frame_ready(frame_ready), .frame_valid(frame_valid),
        .frame_data(frame_data), .level(level), .drop(drop),
        .drop_cnt(drop_cnt), .parity_err(parity_err)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [FW-1:0] exp_q[$];
    int exp_drops = 0;
    int exp_perr  = 0;
    int exp_dcnt  = 0;
    int drop_seen = 0;
    int perr_seen = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted head frame is compared against the model queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (drop) drop_seen++;
            if (parity_err) perr_seen++;
            if (frame_valid && frame_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pop", 32'(frame_data), 32'hDEAD);
                end else begin
                    check("pop_data", 32'(frame_data), 32'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // One beat; optionally pulse frame_ready exactly in the capture cycle.
    task automatic send_beat(input logic [LANE_W-1:0] b, input bit pulse_ready);
        mosi = b;
        tick(1);
        spi_clk = 1'b1;
        tick(2);
        if (pulse_ready) frame_ready = 1'b1;
        tick(1);
        if (pulse_ready) frame_ready = 1'b0;
        spi_clk = 1'b0;
        tick(3);
    endtask

    // Reference model: what the FIFO does with a completed frame.
    task automatic model_frame(input logic [FW-1:0] f, input bit bad_par, input bit pop_last);
        if (PAR_EN && bad_par) begin
            exp_perr++;
        end else if (exp_q.size() < DEPTH || pop_last) begin
            exp_q.push_back(f);
        end else begin
            exp_drops++;
            if (exp_dcnt != 255) exp_dcnt++;
        end
    endtask

    task automatic send_frame(input logic [FW-1:0] f, input bit bad_par, input bit pop_last);
        logic [LANE_W-1:0] b, par;
        par   = '0;
        spi_w = 1'b1;
        tick(3);
        for (int i = 0; i < int'(FIELDS); i++) begin
            b   = f[(FIELDS-1-i)*LANE_W +: LANE_W];
            par = par ^ b;
            send_beat(b, pop_last && !PAR_EN && (i == int'(FIELDS) - 1));
        end
        if (PAR_EN) send_beat(bad_par ? ~par : par, pop_last);
        model_frame(f, bad_par, pop_last);
    endtask

    task automatic send_partial(input int k);
        spi_w = 1'b1;
        tick(3);
        for (int i = 0; i < k; i++) send_beat(LANE_W'($urandom()), 1'b0);
        spi_w = 1'b0;
        tick(4);
        spi_w = 1'b1;
    endtask

    task automatic drain();
        frame_ready = 1'b1;
        tick(DEPTH + 3);
        frame_ready = 1'b0;
        tick(1);
    endtask

    initial begin
        int d0;
        rst = 1'b1; spi_clk = 1'b0; spi_w = 1'b0; mosi = '0; frame_ready = 1'b0;
        tick(3);
        check("rst_level", 32'(level), 0);
        check("rst_valid", 32'(frame_valid), 0);
        check("rst_data", 32'(frame_data), 0);
        check("rst_drop", 32'(drop), 0);
        check("rst_drop_cnt", 32'(drop_cnt), 0);
        check("rst_parity_err", 32'(parity_err), 0);
        rst = 1'b0;
        tick(2);

        // Single frame 1,2,3,4,5 then a one-cycle accept.
        send_frame(20'h12345, 1'b0, 1'b0);
        tick(1);
        check("one_valid", 32'(frame_valid), 1);
        check("one_level", 32'(level), 1);
        check("one_data", 32'(frame_data), 32'h12345);
        frame_ready = 1'b1;
        tick(1);
        frame_ready = 1'b0;
        tick(1);
        check("one_valid_after_pop", 32'(frame_valid), 0);
        check("one_level_after_pop", 32'(level), 0);

        // Three frames with no consumer: third is dropped.
        d0 = drop_seen;
        send_frame(20'hA0A1A, 1'b0, 1'b0);
        send_frame(20'hB1B2B, 1'b0, 1'b0);
        send_frame(20'hC3C4C, 1'b0, 1'b0);
        tick(1);
        check("full_level", 32'(level), 2);
        check("full_drop_cnt", 32'(drop_cnt), 32'(exp_dcnt));
        check("full_drop_pulses", 32'(drop_seen - d0), 1);
        check("full_head", 32'(frame_data), 32'hA0A1A);
        drain();
        check("full_drained", 32'(frame_valid), 0);

        // Partial frame abandoned by spi_w, then a full frame.
        send_partial(3);
        send_frame(20'h6789A, 1'b0, 1'b0);
        tick(1);
        check("abort_level", 32'(level), 1);
        check("abort_data", 32'(frame_data), 32'h6789A);
        drain();

        // Push into a full FIFO while the head is accepted in the same cycle.
        d0 = drop_seen;
        send_frame(20'h11111, 1'b0, 1'b0);
        send_frame(20'h22222, 1'b0, 1'b0);
        send_frame(20'h33333, 1'b0, 1'b1);
        tick(1);
        check("pushpop_level", 32'(level), 2);
        check("pushpop_no_drop", 32'(drop_seen - d0), 0);
        check("pushpop_drop_cnt", 32'(drop_cnt), 32'(exp_dcnt));
        check("pushpop_head", 32'(frame_data), 32'h22222);
        drain();

        if (PAR_EN) begin
            d0 = perr_seen;
            send_frame(20'h12345, 1'b0, 1'b0);
            send_frame(20'h12345, 1'b1, 1'b0);
            tick(1);
            check("parity_level", 32'(level), 1);
            check("parity_err_pulses", 32'(perr_seen - d0), 1);
            drain();
        end

        // Randomized bursts and random consumer back-pressure.
        for (int it = 0; it < 30; it++) begin
            int n;
            frame_ready = 1'b0;
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(0, 3) == 0) send_partial($urandom_range(1, FIELDS - 1));
                send_frame(FW'($urandom()), PAR_EN && ($urandom_range(0, 4) == 0), 1'b0);
            end
            tick(1);
            check("rand_level", 32'(level), 32'(exp_q.size()));
            repeat (8) begin
                frame_ready = 1'($urandom_range(0, 1));
                tick(1);
            end
            drain();
            check("rand_drained", 32'(frame_valid), 0);
        end
        check("rand_drop_cnt", 32'(drop_cnt), 32'(exp_dcnt));

        // Reset mid-frame with a stored frame discards everything.
        send_frame(20'h55AA5, 1'b0, 1'b0);
        spi_w = 1'b1;
        send_beat(4'h9, 1'b0);
        send_beat(4'h8, 1'b0);
        rst = 1'b1;
        tick(2);
        exp_q.delete();
        exp_dcnt = 0;
        check("mid_rst_level", 32'(level), 0);
        check("mid_rst_valid", 32'(frame_valid), 0);
        check("mid_rst_data", 32'(frame_data), 0);
        check("mid_rst_drop_cnt", 32'(drop_cnt), 0);
        rst = 1'b0;
        tick(1);
        send_frame(20'hFEDCB, 1'b0, 1'b0);
        tick(1);
        check("post_rst_data", 32'(frame_data), 32'hFEDCB);
        check("post_rst_level", 32'(level), 1);
        drain();

        check("total_drop_pulses", 32'(drop_seen), 32'(exp_drops));
        check("total_parity_pulses", 32'(perr_seen), 32'(exp_perr));
        check("leftover_frames", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
